warp_issue_scheduler: RTL
=========================

WARP_ISSUE_SCHEDULER -- requirements
Module: warp_issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 16: warps per MP, 2..64.
REQ-002 SHALL have parameter WARPID_DEPTH, default $clog2(NUM_WARPS): warp ID width.
REQ-003 SHALL have parameter MODE, default 0: 0 = round robin, 1 = greedy (keep last warp while ready).
REQ-004 SHALL have parameter AGE_LIMIT, default 15: starvation threshold in cycles; only used with WARP_SCHED_AGE_EN.
REQ-005 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1: reset; asynchronous and active-high.
REQ-007 SHALL have port ready, input, NUM_WARPS: per-warp ready-to-issue bits.
REQ-008 SHALL have port issue_ready, input, 1: pipeline accepts the offered warp this cycle.
REQ-009 SHALL have port flush, input, 1: synchronous discard of offer; resets the priority pointer.
REQ-010 SHALL have port valid, output, 1: registered; a warp is being offered.
REQ-011 SHALL have port selected, output, WARPID_DEPTH: registered; offered warp ID.

Function
REQ-012 SHALL treat a cycle with valid=1 and issue_ready=1 as an accept; no other condition consumes the offer.
REQ-013 SHALL hold valid and selected unchanged while valid=1 and issue_ready=0, even if ready[selected] drops.
REQ-014 SHALL evaluate a new candidate on every edge where valid=0 or an accept occurs; on that edge, if any ready bit is set, load valid=1 and the winner, else valid=0 (1-cycle latency ready->valid).
REQ-015 SHALL keep pointer ptr (WARPID_DEPTH bits); round-robin winner = first ready warp at index ptr, ptr+1, ... wrapping modulo NUM_WARPS.
REQ-016 SHALL on every accept set ptr = (selected+1) mod NUM_WARPS, wrapping NUM_WARPS-1 -> 0.
REQ-017 SHALL in MODE 1 choose last accepted warp (last) if ready[last]=1, else the REQ-015 winner; last is invalid after reset/flush.
REQ-018 SHALL support back-to-back accepts: with issue_ready held 1 and warps ready, valid stays 1 and a new warp is offered each cycle.
REQ-019 SHALL on flush=1 set valid=0, ptr=0, last invalid, at the edge; flush overrides accept and new-candidate load that cycle.
REQ-020 SHALL never offer a warp whose ready bit was 0 at the selection edge.

Reset
REQ-021 SHALL on rst=1, immediately and independent of clk, set valid=0, selected=0, ptr=0, last invalid, all age counters 0.
REQ-022 SHALL drop an in-flight offer on rst mid-handshake with no accept recorded; first selection after release starts at warp 0.

Configuration
REQ-023 SHALL compile starvation protection only when macro WARP_SCHED_AGE_EN is defined.
REQ-024 SHALL with WARP_SCHED_AGE_EN keep per-warp saturating counters: +1 each cycle ready=1 and warp not accepted; cleared on accept of that warp or ready=0; saturate at AGE_LIMIT.
REQ-025 SHALL with WARP_SCHED_AGE_EN give any warp at AGE_LIMIT precedence over REQ-015/REQ-017 (lowest index among saturated warps wins).
REQ-026 SHALL without WARP_SCHED_AGE_EN contain no age counters; selection purely per REQ-015/REQ-017; AGE_LIMIT ignored.

Verification (NUM_WARPS=4 unless noted)
REQ-027 SHALL cover: rst released, ready=4'b1111, issue_ready=1, MODE 0 -> selected 0,1,2,3,0 on consecutive cycles, valid=1 throughout.
REQ-028 SHALL cover: ready=4'b0100, issue_ready=0 for 5 cycles then ready=0 -> valid=1, selected=2 held all 5 cycles; accept next cycle -> valid=0 following edge.
REQ-029 SHALL cover: MODE 1, ready=4'b1011, issue_ready=1 -> selected 0 repeatedly; drop ready[0] -> selected 1, then 1 repeatedly.
REQ-030 SHALL cover: valid=1 selected=3, flush=1 with issue_ready=1 -> valid=0 next cycle; ready=4'b1111 then -> selected=0.
REQ-031 SHALL cover: rst pulsed between clock edges while valid=1 -> valid=0 and selected=0 before next edge.
REQ-032 SHALL cover, WARP_SCHED_AGE_EN, MODE 1, AGE_LIMIT=3: ready=4'b0011 constant, issue_ready=1 -> warp 0 issued until warp 1 age reaches 3, then warp 1 issued exactly once, then warp 0 resumes.

Source files
------------

// File: rtl/warp_issue_scheduler.sv
// Per-MP warp issue scheduler: registered offer/accept handshake with round-robin or greedy selection.
// Optional starvation protection (per-warp age counters) is compiled in when WARP_SCHED_AGE_EN is defined.
module warp_issue_scheduler #(
   parameter int NUM_WARPS    = 16,
   parameter int WARPID_DEPTH = $clog2(NUM_WARPS),
   parameter int MODE         = 0,
   parameter int AGE_LIMIT    = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_WARPS-1:0]    ready,
   input  logic                    issue_ready,
   input  logic                    flush,
   output logic                    valid,
   output logic [WARPID_DEPTH-1:0] selected
);

   logic                    accept;
   logic                    load;
   logic                    any_ready;
   logic [WARPID_DEPTH-1:0] ptr;
   logic [WARPID_DEPTH-1:0] eff_ptr;
   logic [WARPID_DEPTH-1:0] last;
   logic                    last_valid;
   logic [WARPID_DEPTH-1:0] eff_last;
   logic                    eff_last_valid;
   logic                    offer_aged;
   logic                    rr_found;
   logic [WARPID_DEPTH-1:0] rr_winner;
   logic                    aged_found;
   logic [WARPID_DEPTH-1:0] aged_winner;
   logic [WARPID_DEPTH-1:0] winner;

   assign accept    = valid & issue_ready;
   assign load      = ~valid | accept;
   assign any_ready = |ready;

   // Selection sees the state as it will be after this edge's accept, so back-to-back issue
   // advances the pointer and the greedy warp without a bubble cycle.
   always_comb begin
      eff_ptr        = ptr;
      eff_last       = last;
      eff_last_valid = last_valid;
      if (accept) begin
         eff_ptr = (selected == WARPID_DEPTH'(NUM_WARPS - 1)) ? '0 : selected + 1'b1;
         if (!offer_aged) begin
            eff_last       = selected;
            eff_last_valid = 1'b1;
         end
      end
   end

   always_comb begin
      int idx;
      rr_found  = 1'b0;
      rr_winner = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         idx = (int'(eff_ptr) + i) % NUM_WARPS;
         if (!rr_found && ready[idx]) begin
            rr_found  = 1'b1;
            rr_winner = WARPID_DEPTH'(idx);
         end
      end
   end

`ifdef WARP_SCHED_AGE_EN
   localparam int AGE_W = $clog2(AGE_LIMIT + 1);

   logic [AGE_W-1:0] age [NUM_WARPS];

   // A warp being accepted this edge is excluded so a starved warp is served exactly once.
   always_comb begin
      aged_found  = 1'b0;
      aged_winner = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         if (!aged_found && ready[i] && age[i] == AGE_W'(AGE_LIMIT) &&
             !(accept && selected == WARPID_DEPTH'(i))) begin
            aged_found  = 1'b1;
            aged_winner = WARPID_DEPTH'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_WARPS; i++) age[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_WARPS; i++) begin
            if (!ready[i] || (accept && selected == WARPID_DEPTH'(i)))
               age[i] <= '0;
            else if (age[i] != AGE_W'(AGE_LIMIT))
               age[i] <= age[i] + 1'b1;
         end
      end
   end
`else
   assign aged_found  = 1'b0;
   assign aged_winner = '0;
`endif

   always_comb begin
      winner = rr_winner;
      if (aged_found)
         winner = aged_winner;
      else if (MODE == 1 && eff_last_valid && ready[eff_last])
         winner = eff_last;
   end

   // An aged offer does not become the greedy warp, so the interrupted warp resumes afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid      <= 1'b0;
         selected   <= '0;
         ptr        <= '0;
         last       <= '0;
         last_valid <= 1'b0;
      end else if (flush) begin
         valid      <= 1'b0;
         ptr        <= '0;
         last_valid <= 1'b0;
      end else begin
         if (accept) begin
            ptr        <= eff_ptr;
            last       <= eff_last;
            last_valid <= eff_last_valid;
         end
         if (load) begin
            valid <= any_ready;
            if (any_ready) selected <= winner;
         end
      end
   end

`ifdef WARP_SCHED_AGE_EN
   logic offer_aged_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         offer_aged_q <= 1'b0;
      else if (flush)
         offer_aged_q <= 1'b0;
      else if (load)
         offer_aged_q <= any_ready & aged_found;
   end

   assign offer_aged = offer_aged_q;
`else
   assign offer_aged = 1'b0;
`endif

endmodule
